// File: rtl/fwrisc_regfile_mp_if.sv
// fwrisc_regfile_mp_if
//   Bundles the decode-side read ports, the writeback write port and the
//   clear handshake of the multi-port register file.
//   Parameters: WIDTH (data bits), AW (address bits, must equal
//   $clog2(DEPTH) of the attached register file), NUM_RD (read ports).
//   Signals:
//     rs_raddr  NUM_RD*AW     read addresses, port i at [i*AW +: AW]
//     rs_rdata  NUM_RD*WIDTH  registered read data, port i at [i*WIDTH +: WIDTH]
//     rd_waddr  AW            write address
//     rd_wdata  WIDTH         write data
//     rd_wen    1             write enable
//     clear_req 1             single-cycle clear request
//     busy      1             clear sequencer running
//   Modports: master (pipeline side), slave (register file).
interface fwrisc_regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int AW     = 6,
  parameter int NUM_RD = 2
) ();
  logic [NUM_RD*AW-1:0]    rs_raddr;
  logic [NUM_RD*WIDTH-1:0] rs_rdata;
  logic [AW-1:0]           rd_waddr;
  logic [WIDTH-1:0]        rd_wdata;
  logic                    rd_wen;
  logic                    clear_req;
  logic                    busy;

  modport master (
    output rs_raddr, rd_waddr, rd_wdata, rd_wen, clear_req,
    input  rs_rdata, busy
  );

  modport slave (
    input  rs_raddr, rd_waddr, rd_wdata, rd_wen, clear_req,
    output rs_rdata, busy
  );
endinterface

// File: rtl/fwrisc_regfile_mp.sv
// fwrisc_regfile_mp
//   Parametrised register file with NUM_RD independent registered read
//   ports, one write port, optional hardwired zero register and a clear
//   sequencer that zeroes the array after reset and on clear_req.
//   Ports:
//     clock  rising-edge clock for all state
//     reset  asynchronous, active-low reset
//     bus    fwrisc_regfile_mp_if.slave (read ports, write port,
//            clear_req, busy)
//   Parameters: WIDTH, DEPTH (>=2, any value), NUM_RD (1..4),
//   ZERO_REG (1 = address 0 reads zero and ignores writes).
//   Optional feature macro: FWRISC_REGFILE_BYPASS_EN
//     defined   -> an accepted write is forwarded to any read port reading
//                  the same address in the same cycle (write-first)
//     undefined -> read-first, the array value before the write is seen
module fwrisc_regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clock,
  input  logic                reset,
  fwrisc_regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  // Extra bit so a power-of-two DEPTH is representable in the compare.
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  // Storage has no reset so it can map onto block RAM; the clear
  // sequencer is what gives it a defined value.
  logic [WIDTH-1:0] mem [DEPTH];

  logic                    clearing;
  logic                    wr_ok;
  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [WIDTH-1:0]        mem_wdata;
  logic [NUM_RD*WIDTH-1:0] rdata_reg, rdata_next;

  assign clearing = (state_reg == S_CLEAR);
  assign bus.busy = clearing;

  // ------------------------------------------------------------------
  // Clear sequencer
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= S_CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_CLEAR: begin
        // clear_req is deliberately ignored here: a running clear is
        // never restarted.
        if (cnt_reg == LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.clear_req) begin
          state_next = S_CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Write port: the sequencer owns the array while clearing; otherwise
  // a pipeline write is accepted only when in range and not aimed at
  // the hardwired zero register.
  // ------------------------------------------------------------------
  assign wr_ok = !clearing && bus.rd_wen &&
                 ({1'b0, bus.rd_waddr} < DEPTH_W) &&
                 !((ZERO_REG != 0) && (bus.rd_waddr == '0));

  assign mem_we    = clearing || wr_ok;
  assign mem_waddr = clearing ? cnt_reg : bus.rd_waddr;
  assign mem_wdata = clearing ? '0 : bus.rd_wdata;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ------------------------------------------------------------------
  // Read ports
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]    ra;
      logic             blank;
      logic [WIDTH-1:0] arr;

      assign ra = bus.rs_raddr[gi*AW +: AW];

      // Zero-forcing rules win over both the array and any forwarding.
      assign blank = clearing ||
                     ({1'b0, ra} >= DEPTH_W) ||
                     ((ZERO_REG != 0) && (ra == '0));

`ifdef FWRISC_REGFILE_BYPASS_EN
      assign arr = (wr_ok && (ra == bus.rd_waddr)) ? bus.rd_wdata : mem[ra];
`else
      // The array read samples the pre-write contents (read-first).
      assign arr = mem[ra];
`endif

      assign rdata_next[gi*WIDTH +: WIDTH] = blank ? '0 : arr;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  assign bus.rs_rdata = rdata_reg;

endmodule

// File: tb/tb_fwrisc_regfile_mp.sv
// tb_fwrisc_regfile_mp
//   Randomised plus directed stimulus against a behavioural model of the
//   register file. The stimulus process drives inputs on the falling edge
//   and queues the values expected after the next rising edge; a monitor
//   process pops and compares after every rising edge.
module tb_fwrisc_regfile_mp;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 40;
  localparam int NUM_RD   = 3;
  localparam int ZERO_REG = 1;
  localparam int AW       = $clog2(DEPTH);
  localparam int AMAX     = DEPTH + 7;

`ifdef FWRISC_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [NUM_RD*WIDTH-1:0] rd;
    logic                    busy;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fwrisc_regfile_mp_if #(.WIDTH(WIDTH), .AW(AW), .NUM_RD(NUM_RD)) bus ();

  fwrisc_regfile_mp #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model state: register contents plus remaining clear cycles.
  logic [WIDTH-1:0] model_mem [DEPTH];
  int               clear_left;
  exp_t             exp_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int txn         = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Model one rising edge with the given inputs and queue the outcome.
  task automatic apply(input logic [NUM_RD*AW-1:0] ra, input int wa,
                       input logic [WIDTH-1:0] wd, input bit we, input bit cr);
    exp_t e;
    bit   busy_b;
    bit   wr_ok;
    int   a;
    bus.rs_raddr  = ra;
    bus.rd_waddr  = AW'(wa);
    bus.rd_wdata  = wd;
    bus.rd_wen    = we;
    bus.clear_req = cr;

    busy_b = (clear_left > 0);
    wr_ok  = !busy_b && we && (wa < DEPTH) && !(ZERO_REG != 0 && wa == 0);
    e.rd   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = int'(ra[i*AW +: AW]);
      if (busy_b || a >= DEPTH || (ZERO_REG != 0 && a == 0))
        e.rd[i*WIDTH +: WIDTH] = '0;
      else if (BYP && wr_ok && a == wa)
        e.rd[i*WIDTH +: WIDTH] = wd;
      else
        e.rd[i*WIDTH +: WIDTH] = model_mem[a];
    end

    if (wr_ok) model_mem[wa] = wd;
    if (busy_b) begin
      clear_left--;
      if (clear_left == 0)
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
    end else if (cr) begin
      clear_left = DEPTH;
    end
    e.busy = (clear_left > 0);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NUM_RD*AW-1:0] ra, input int wa,
                      input logic [WIDTH-1:0] wd, input bit we, input bit cr);
    @(negedge clock);
    apply(ra, wa, wd, we, cr);
  endtask

  function automatic logic [NUM_RD*AW-1:0] all_ports(input int a);
    logic [NUM_RD*AW-1:0] r;
    for (int i = 0; i < NUM_RD; i++) r[i*AW +: AW] = AW'(a);
    return r;
  endfunction

  function automatic logic [NUM_RD*AW-1:0] rand_ports();
    logic [NUM_RD*AW-1:0] r;
    for (int i = 0; i < NUM_RD; i++)
      r[i*AW +: AW] = AW'(($urandom % 2) ? $urandom_range(0, 15)
                                         : $urandom_range(0, AMAX));
    return r;
  endfunction

  task automatic idle_read(input logic [NUM_RD*AW-1:0] ra);
    step(ra, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic write_only(input int wa, input logic [WIDTH-1:0] wd);
    step(rand_ports(), wa, wd, 1'b1, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset      = 1'b1;
    clear_left = DEPTH;
    apply(rand_ports(), 0, '0, 1'b0, 1'b0);
  endtask

  // Assert reset on a falling edge and check outputs drop at once.
  task automatic pulse_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check({tag, " rdata0"}, bus.rs_rdata[0 +: WIDTH], '0);
    check({tag, " rdata_all"}, WIDTH'(bus.rs_rdata != '0), '0);
    check({tag, " busy"}, WIDTH'(bus.busy), WIDTH'(1));
    repeat (2) @(negedge clock);
    release_reset();
  endtask

  // Monitor: one comparison set per rising edge that has a queued result.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d raddr=%h busy=%b rdata=%h", txn, bus.rs_raddr,
                 bus.busy, bus.rs_rdata);
        for (int i = 0; i < NUM_RD; i++)
          check($sformatf("rdata port %0d", i), bus.rs_rdata[i*WIDTH +: WIDTH],
                e.rd[i*WIDTH +: WIDTH]);
        check("busy", WIDTH'(bus.busy), WIDTH'(e.busy));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied",
             vectors);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [NUM_RD*AW-1:0] ra;
    int                   wa;
    bus.rs_raddr  = '0;
    bus.rd_waddr  = '0;
    bus.rd_wdata  = '0;
    bus.rd_wen    = 1'b0;
    bus.clear_req = 1'b0;
    clear_left    = DEPTH;
    for (int k = 0; k < DEPTH; k++) model_mem[k] = 'x;

    // Reset state
    #12;
    check("reset rdata", WIDTH'(bus.rs_rdata != '0), '0);
    check("reset busy", WIDTH'(bus.busy), WIDTH'(1));
    release_reset();

    // Initial clear runs out; then every address reads zero.
    repeat (DEPTH + 1) idle_read(rand_ports());
    for (int a = 0; a <= AMAX; a++) idle_read(all_ports(a));

    // Basic write then read on all ports.
    write_only(5, 32'hDEADBEEF);
    idle_read(all_ports(5));

    // Hardwired zero register.
    write_only(0, 32'h12345678);
    idle_read(all_ports(0));
    write_only(1, 32'h12345678);
    idle_read(all_ports(1));

    // Same-cycle write and read of one address.
    write_only(7, 32'h11111111);
    step(all_ports(7), 7, 32'hA5A5A5A5, 1'b1, 1'b0);
    idle_read(all_ports(7));

    // Clear request with a write attempt in the middle of the clear.
    write_only(3, 32'h1);
    write_only(9, 32'h1);
    step(all_ports(3), 0, '0, 1'b0, 1'b1);
    for (int k = 0; k < DEPTH + 2; k++) begin
      ra = rand_ports();
      ra[0 +: AW] = AW'(3);
      ra[AW +: AW] = AW'(9);
      step(ra, 3, 32'hFF, (k == 10), (k == 5));
    end
    ra = all_ports(3);
    ra[AW +: AW] = AW'(9);
    idle_read(ra);

    // Out-of-range write is dropped.
    write_only(45, 32'hCAFEF00D);
    idle_read(all_ports(45));

    // Write and clear requested in the same cycle.
    step(all_ports(4), 4, 32'h0BADC0DE, 1'b1, 1'b1);
    repeat (DEPTH + 1) idle_read(all_ports(4));

    // Reset while a non-zero value is on the read port.
    write_only(2, 32'h5A5A0001);
    idle_read(all_ports(2));
    pulse_reset("reset idle");
    repeat (DEPTH + 1) idle_read(rand_ports());

    // Reset in the middle of a clear; a full clear follows release.
    step(rand_ports(), 0, '0, 1'b0, 1'b1);
    repeat (20) idle_read(rand_ports());
    pulse_reset("reset mid-clear");
    repeat (DEPTH + 1) idle_read(rand_ports());

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      ra = rand_ports();
      wa = ($urandom % 2) ? $urandom_range(0, 15) : $urandom_range(0, AMAX);
      if ($urandom % 4 == 0) ra[($urandom % NUM_RD)*AW +: AW] = AW'(wa);
      step(ra, wa, $urandom, ($urandom % 2) == 1, ($urandom % 150) == 0);
    end

    @(negedge clock);
    @(negedge clock);
    check("scoreboard drained", WIDTH'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwrisc_regfile_mp.md
Name: fwrisc_regfile_mp

Overview:
Parametrised multi-read-port register file. It is the successor to the fixed 64x32, two-read-port FWRISC register file.
- Synchronous (registered) read data, so it maps onto block RAM.
- Optional hardwired zero register.
- A clear sequencer that zeroes the array after reset and on request.
- Sits between the decode stage (read addresses) and the writeback stage (write port). Signals busy while clearing.

Parameters:
WIDTH, 32, data width in bits
DEPTH, 64, number of registers (need not be a power of 2; minimum 2)
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = address 0 reads as zero and writes to it are discarded
AW (localparam), $clog2(DEPTH), address width

Ports:
clock  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
rs_raddr  in  NUM_RD*AW  read addresses; port i is at [i*AW +: AW]
rs_rdata  out  NUM_RD*WIDTH  registered read data; port i is at [i*WIDTH +: WIDTH]
rd_waddr  in  AW  write address
rd_wdata  in  WIDTH  write data
rd_wen  in  1  write enable
clear_req  in  1  single-cycle pulse requesting a full clear
busy  out  1  1 while the clear sequencer is running

Behaviour:
- Reset (reset=0, asynchronous):
  - rs_rdata = 0, state = CLEAR, clear counter = 0, busy = 1.
  - Array contents are undefined until the clear completes.
- FSM states: CLEAR, IDLE.
  - CLEAR: every cycle, writes 0 to regs[cnt] and increments cnt. When cnt == DEPTH-1, the write occurs and the next state is IDLE. A clear therefore takes exactly DEPTH cycles; busy drops on the cycle after the last write.
  - IDLE: clear_req=1 -> CLEAR next cycle, with cnt = 0 and busy = 1 from that cycle.
  - clear_req during CLEAR is ignored; it does not restart the clear.
- Writes:
  - In IDLE, rd_wen=1 writes rd_wdata to regs[rd_waddr] at the clock edge.
  - Write is dropped in each of these cases: during CLEAR; rd_waddr >= DEPTH; ZERO_REG=1 and rd_waddr == 0.
- Reads (latency 1):
  - rs_rdata[i] is registered from regs[rs_raddr[i]] at the clock edge.
  - Output is 0 in each of these cases: rs_raddr[i] >= DEPTH; ZERO_REG=1 and address 0; state is CLEAR.
  - All ports are independent; identical addresses on several ports are legal.
  - While busy, rs_rdata loads 0 every cycle.
- Same-cycle write and read of the same address (no bypass): the read returns the OLD contents (read-first), matching block-RAM behaviour.
- Simultaneous clear_req and rd_wen in IDLE: the write commits in that cycle, and the clear starts next cycle and overwrites it.
- Reset asserted mid-clear or mid-operation: immediate return to the reset state above; the clear restarts from 0 after release.

Optional Feature:
FWRISC_REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. In IDLE, if rd_wen=1 and the write is not dropped, any read port with rs_raddr[i] == rd_waddr registers rd_wdata instead of the array value (write-first). Zero-register, out-of-range and busy rules still take precedence.
- Undefined: read-first as specified above. No forwarding logic is instantiated.

Test Plan:
- Reset release with DEPTH=64: busy=1 for exactly 64 cycles, then 0. Every address read afterwards returns 0x00000000.
- Write 0xDEADBEEF to addr 5, then next cycle read addr 5 on port 0 and port 1. Both ports show 0xDEADBEEF one cycle after the address is presented.
- ZERO_REG=1: write 0x12345678 to addr 0, then read addr 0. Returns 0. A write to addr 1 with the same data reads back 0x12345678.
- Same-cycle write of 0xA5A5A5A5 to addr 7 (old value 0x11111111) and read of addr 7:
  - Without the macro: 0x11111111.
  - With FWRISC_REGFILE_BYPASS_EN: 0xA5A5A5A5.
  - The following read returns 0xA5A5A5A5 in both builds.
- Write 0x1 to addrs 3 and 9, pulse clear_req, and attempt a write of 0xFF to addr 3 at clear cycle 10.
  - busy is high for DEPTH cycles.
  - During clear, reads return 0.
  - After clear, addrs 3 and 9 read 0.
- DEPTH=40, NUM_RD=3:
  - Write to addr 45 is dropped; reading addr 45 returns 0.
  - Assert reset low mid-clear at cycle 20: rs_rdata = 0 immediately, and a full 40-cycle clear follows release.
